// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the instruction-sequencing controller.
// Opcodes live in ir[15:12]; states are exported on the debug port.
package ctrl_pkg;

   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_LOAD_A = 4'd3,
      ST_LOAD_B = 4'd4,
      ST_STORE  = 4'd5,
      ST_ADD    = 4'd6,
      ST_SUB    = 4'd7,
      ST_LDI    = 4'd8,
      ST_JMP    = 4'd9,
      ST_JZ     = 4'd10,
      ST_NOOP   = 4'd11,
      ST_HALT   = 4'd12,
      ST_FAULT  = 4'd13
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_HALT  = 4'd5;
   localparam logic [3:0] OP_LDI   = 4'd6;
   localparam logic [3:0] OP_JMP   = 4'd7;
   localparam logic [3:0] OP_JZ    = 4'd8;

   localparam logic [1:0] RFS_ALU = 2'b00;
   localparam logic [1:0] RFS_MEM = 2'b01;
   localparam logic [1:0] RFS_IMM = 2'b10;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   // States that hold a request open until memory acknowledges it.
   function automatic logic is_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_LOAD_A) || (s == ST_STORE);
   endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction/data memory handshake bundle between controller and memories.
// master = controller side, slave = memory side.
interface control_fsm_if #(
   parameter int unsigned RF_AW = 4
) ();
   import ctrl_pkg::*;

   localparam int unsigned DMEM_AW = 2 * RF_AW;
   localparam int unsigned DATA_W  = 4 * RF_AW;

   logic [DATA_W-1:0]  ir;
   logic               i_ack;
   logic               d_ack;
   logic               i_req;
   logic               ir_ld;
   logic [DMEM_AW-1:0] d_addr;
   logic               d_req;
   logic               d_wr;

   modport master (
      input  ir, i_ack, d_ack,
      output i_req, ir_ld, d_addr, d_req, d_wr
   );

   modport slave (
      output ir, i_ack, d_ack,
      input  i_req, ir_ld, d_addr, d_req, d_wr
   );

endinterface

// File: rtl/ctrl_wdog.sv
// Memory-wait watchdog: counts consecutive cycles spent waiting for an ack
// and flags expiry in the TIMEOUT-th waiting cycle of a state.
module ctrl_wdog #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic expire
);
   import ctrl_pkg::*;

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // Waiting-cycle counter; cleared whenever the FSM is not stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (count_en)
         cnt <= cnt + CW'(1);
   end

   // Expiry in the TIMEOUT-th cycle only if the ack is still missing then.
   always_comb begin
      expire = count_en && (cnt == LAST);
   end

endmodule

// File: rtl/control_fsm.sv
// Instruction-sequencing controller with handshaked memories, LDI/JMP/JZ,
// resumable HALT and a memory-wait watchdog that traps to FAULT.
// Build option: define CTRL_BRANCH_EN to compile in JMP and JZ.
module control_fsm #(
   parameter int unsigned RF_AW   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 Reset,
   control_fsm_if.master        bus,
   input  logic                 alu_zero,
   input  logic                 resume,
   output logic                 pc_clr,
   output logic                 pc_up,
   output logic                 pc_ld,
   output logic [2*RF_AW-1:0]   pc_val,
   output logic [1:0]           rf_s,
   output logic [4*RF_AW-1:0]   rf_imm,
   output logic [RF_AW-1:0]     rf_w_addr,
   output logic [RF_AW-1:0]     rf_ra_addr,
   output logic [RF_AW-1:0]     rf_rb_addr,
   output logic                 rf_w_en,
   output logic [2:0]           alu_sel,
   output logic [3:0]           state,
   output logic                 halted,
   output logic                 fault
);
   import ctrl_pkg::*;

   localparam int unsigned DMEM_AW = 2 * RF_AW;
   localparam int unsigned DATA_W  = 4 * RF_AW;

   state_t st;
   logic   ack_now;
   logic   wd_count;
   logic   wd_clear;
   logic   wd_expire;

   // Ack relevant to the current wait state.
   always_comb begin
      ack_now  = (st == ST_FETCH) ? bus.i_ack : bus.d_ack;
      wd_count = is_wait_state(st) && !ack_now;
      wd_clear = !wd_count;
   end

   ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk      (clk),
      .rst_n    (Reset),
      .clear    (wd_clear),
      .count_en (wd_count),
      .expire   (wd_expire)
   );

   // State register and transition logic; watchdog expiry overrides all.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         st <= ST_INIT;
      end else if (wd_expire) begin
         st <= ST_FAULT;
      end else begin
         case (st)
            ST_INIT:   st <= ST_FETCH;
            ST_FETCH:  if (bus.i_ack) st <= ST_DECODE;
            ST_DECODE: begin
               case (bus.ir[15:12])
                  OP_STORE: st <= ST_STORE;
                  OP_LOAD:  st <= ST_LOAD_A;
                  OP_ADD:   st <= ST_ADD;
                  OP_SUB:   st <= ST_SUB;
                  OP_HALT:  st <= ST_HALT;
                  OP_LDI:   st <= ST_LDI;
`ifdef CTRL_BRANCH_EN
                  OP_JMP:   st <= ST_JMP;
                  OP_JZ:    st <= ST_JZ;
`endif
                  default:  st <= ST_NOOP;
               endcase
            end
            ST_LOAD_A: if (bus.d_ack) st <= ST_LOAD_B;
            ST_LOAD_B: st <= ST_FETCH;
            ST_STORE:  if (bus.d_ack) st <= ST_FETCH;
            ST_ADD:    st <= ST_FETCH;
            ST_SUB:    st <= ST_FETCH;
            ST_LDI:    st <= ST_FETCH;
`ifdef CTRL_BRANCH_EN
            ST_JMP:    st <= ST_FETCH;
            ST_JZ:     st <= ST_FETCH;
`endif
            ST_NOOP:   st <= ST_FETCH;
            ST_HALT:   if (resume) st <= ST_FETCH;
            ST_FAULT:  st <= ST_FAULT;
            default:   st <= ST_INIT;
         endcase
      end
   end

   // Datapath controls decoded from state, ir and the memory acks.
   always_comb begin
      pc_clr     = 1'b0;
      pc_up      = 1'b0;
      pc_ld      = 1'b0;
      pc_val     = '0;
      bus.i_req  = 1'b0;
      bus.ir_ld  = 1'b0;
      bus.d_addr = '0;
      bus.d_req  = 1'b0;
      bus.d_wr   = 1'b0;
      rf_s       = RFS_ALU;
      rf_imm     = '0;
      rf_w_addr  = '0;
      rf_ra_addr = '0;
      rf_rb_addr = '0;
      rf_w_en    = 1'b0;
      alu_sel    = ALU_PASS;
      halted     = 1'b0;
      fault      = 1'b0;
      case (st)
         ST_INIT: pc_clr = 1'b1;
         ST_FETCH: begin
            bus.i_req = 1'b1;
            bus.ir_ld = bus.i_ack;
            pc_up     = bus.i_ack;
         end
         ST_LOAD_A: begin
            bus.d_req  = 1'b1;
            bus.d_addr = DMEM_AW'(bus.ir[11:4]);
            rf_s       = RFS_MEM;
            rf_w_addr  = RF_AW'(bus.ir[3:0]);
         end
         ST_LOAD_B: begin
            bus.d_addr = DMEM_AW'(bus.ir[11:4]);
            rf_s       = RFS_MEM;
            rf_w_addr  = RF_AW'(bus.ir[3:0]);
            rf_w_en    = 1'b1;
         end
         ST_STORE: begin
            bus.d_req  = 1'b1;
            bus.d_wr   = 1'b1;
            bus.d_addr = DMEM_AW'(bus.ir[7:0]);
            rf_ra_addr = RF_AW'(bus.ir[11:8]);
         end
         ST_ADD, ST_SUB: begin
            rf_ra_addr = RF_AW'(bus.ir[11:8]);
            rf_rb_addr = RF_AW'(bus.ir[7:4]);
            rf_w_addr  = RF_AW'(bus.ir[3:0]);
            rf_w_en    = 1'b1;
            rf_s       = RFS_ALU;
            alu_sel    = (st == ST_ADD) ? ALU_ADD : ALU_SUB;
         end
         ST_LDI: begin
            rf_s      = RFS_IMM;
            rf_imm    = DATA_W'(bus.ir[11:4]);
            rf_w_addr = RF_AW'(bus.ir[3:0]);
            rf_w_en   = 1'b1;
         end
`ifdef CTRL_BRANCH_EN
         ST_JMP: begin
            pc_ld  = 1'b1;
            pc_val = DMEM_AW'(bus.ir[7:0]);
         end
         ST_JZ: begin
            rf_ra_addr = RF_AW'(bus.ir[11:8]);
            alu_sel    = ALU_PASS;
            pc_val     = DMEM_AW'(bus.ir[7:0]);
            pc_ld      = alu_zero;
         end
`endif
         ST_HALT:  halted = 1'b1;
         ST_FAULT: fault  = 1'b1;
         default: ;
      endcase
   end

   assign state = st;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: table of single-instruction vectors through a
// scoreboard queue, plus hand sequences for waits, HALT, reset and watchdog.
module tb_control_fsm;
   import ctrl_pkg::*;

   typedef struct packed {
      logic        pc_clr;
      logic        pc_up;
      logic        pc_ld;
      logic [7:0]  pc_val;
      logic        i_req;
      logic        ir_ld;
      logic [7:0]  d_addr;
      logic        d_req;
      logic        d_wr;
      logic [1:0]  rf_s;
      logic [15:0] rf_imm;
      logic [3:0]  w_addr;
      logic [3:0]  ra_addr;
      logic [3:0]  rb_addr;
      logic        w_en;
      logic [2:0]  alu_sel;
      logic        halted;
      logic        fault;
   } obs_t;

   typedef struct {
      string       name;
      logic [15:0] ir;
      logic        az;
      state_t      st;
      obs_t        exp;
      int unsigned lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        Reset = 1'b0;
   logic        alu_zero = 1'b0;
   logic        resume = 1'b0;
   logic        pc_clr, pc_up, pc_ld;
   logic [7:0]  pc_val;
   logic [1:0]  rf_s;
   logic [15:0] rf_imm;
   logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
   logic        rf_w_en;
   logic [2:0]  alu_sel;
   logic [3:0]  state;
   logic        halted, fault;

   int unsigned checks = 0;
   int unsigned errors = 0;

   control_fsm_if #(.RF_AW(4)) bus ();

   control_fsm #(.RF_AW(4), .TIMEOUT(16)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .bus        (bus),
      .alu_zero   (alu_zero),
      .resume     (resume),
      .pc_clr     (pc_clr),
      .pc_up      (pc_up),
      .pc_ld      (pc_ld),
      .pc_val     (pc_val),
      .rf_s       (rf_s),
      .rf_imm     (rf_imm),
      .rf_w_addr  (rf_w_addr),
      .rf_ra_addr (rf_ra_addr),
      .rf_rb_addr (rf_rb_addr),
      .rf_w_en    (rf_w_en),
      .alu_sel    (alu_sel),
      .state      (state),
      .halted     (halted),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.pc_clr  = pc_clr;
      o.pc_up   = pc_up;
      o.pc_ld   = pc_ld;
      o.pc_val  = pc_val;
      o.i_req   = bus.i_req;
      o.ir_ld   = bus.ir_ld;
      o.d_addr  = bus.d_addr;
      o.d_req   = bus.d_req;
      o.d_wr    = bus.d_wr;
      o.rf_s    = rf_s;
      o.rf_imm  = rf_imm;
      o.w_addr  = rf_w_addr;
      o.ra_addr = rf_ra_addr;
      o.rb_addr = rf_rb_addr;
      o.w_en    = rf_w_en;
      o.alu_sel = alu_sel;
      o.halted  = halted;
      o.fault   = fault;
      return o;
   endfunction

   function automatic vec_t mkv(input string n, input logic [15:0] i, input logic az,
                                input state_t s, input obs_t e, input int unsigned lat);
      vec_t v;
      v.name = n;
      v.ir   = i;
      v.az   = az;
      v.st   = s;
      v.exp  = e;
      v.lat  = lat;
      return v;
   endfunction

   // From a FETCH cycle: deliver instr with an immediate ack, stop in the
   // first cycle of the execute state.
   task automatic issue(input logic [15:0] instr);
      bus.ir    = instr;
      bus.i_ack = 1'b1;
      #1;
      chk("issue_fetch", 64'(state), 64'(ST_FETCH));
      @(negedge clk);
      bus.i_ack = 1'b0;
      #1;
      chk("issue_decode", 64'(state), 64'(ST_DECODE));
      @(negedge clk);
      #1;
   endtask

   vec_t        vecs [11];
   vec_t        sb [$];
   vec_t        cur;
   obs_t        e;
   obs_t        o;
   int unsigned lat;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "bench time limit reached");
   end

   initial begin
      e = '0;
      vecs[0] = mkv("noop", 16'h0000, 1'b0, ST_NOOP, e, 3);
      e = '0; e.ra_addr = 4'h1; e.rb_addr = 4'h2; e.w_addr = 4'h5; e.w_en = 1'b1; e.alu_sel = 3'b001;
      vecs[1] = mkv("add", 16'h3125, 1'b0, ST_ADD, e, 3);
      e = '0; e.ra_addr = 4'hA; e.rb_addr = 4'h7; e.w_addr = 4'hC; e.w_en = 1'b1; e.alu_sel = 3'b010;
      vecs[2] = mkv("sub", 16'h4A7C, 1'b0, ST_SUB, e, 3);
      e = '0; e.rf_s = 2'b10; e.w_addr = 4'h3; e.w_en = 1'b1; e.rf_imm = 16'h00AB;
      vecs[3] = mkv("ldi", 16'h6AB3, 1'b0, ST_LDI, e, 3);
      e = '0; e.d_req = 1'b1; e.d_wr = 1'b1; e.d_addr = 8'h5C; e.ra_addr = 4'hA;
      vecs[4] = mkv("store", 16'h1A5C, 1'b0, ST_STORE, e, 3);
      e = '0; e.d_req = 1'b1; e.d_addr = 8'hAB; e.rf_s = 2'b01; e.w_addr = 4'h3;
      vecs[5] = mkv("load", 16'h2AB3, 1'b0, ST_LOAD_A, e, 4);
`ifdef CTRL_BRANCH_EN
      e = '0; e.pc_ld = 1'b1; e.pc_val = 8'h42;
      vecs[6] = mkv("jmp", 16'h7F42, 1'b0, ST_JMP, e, 3);
      e = '0; e.ra_addr = 4'h3; e.pc_val = 8'h40; e.pc_ld = 1'b1;
      vecs[7] = mkv("jz_taken", 16'h8340, 1'b1, ST_JZ, e, 3);
      e = '0; e.ra_addr = 4'h3; e.pc_val = 8'h40;
      vecs[8] = mkv("jz_not_taken", 16'h8340, 1'b0, ST_JZ, e, 3);
`else
      e = '0;
      vecs[6] = mkv("jmp_disabled", 16'h7F42, 1'b0, ST_NOOP, e, 3);
      vecs[7] = mkv("jz_disabled_z1", 16'h8340, 1'b1, ST_NOOP, e, 3);
      vecs[8] = mkv("jz_disabled_z0", 16'h8340, 1'b0, ST_NOOP, e, 3);
`endif
      e = '0;
      vecs[9]  = mkv("op_f_noop", 16'hF123, 1'b0, ST_NOOP, e, 3);
      vecs[10] = mkv("op_9_noop", 16'h9FFF, 1'b0, ST_NOOP, e, 3);

      bus.ir = '0; bus.i_ack = 1'b0; bus.d_ack = 1'b0;

      // Reset state
      @(negedge clk); @(negedge clk); #1;
      chk("reset_state", 64'(state), 64'(0));
      e = '0; e.pc_clr = 1'b1;
      chk("reset_outputs", 64'(sample()), 64'(e));
      Reset = 1'b1;
      #1;
      chk("init_pc_clr", 64'(pc_clr), 64'(1));
      @(negedge clk); #1;
      chk("init_to_fetch", 64'(state), 64'(ST_FETCH));
      chk("fetch_req_no_ack", 64'({bus.i_req, bus.ir_ld, pc_up, pc_clr}), 64'(4'b1000));

      // Table-driven zero-wait instructions
      for (int i = 0; i < 11; i++) begin
         bus.ir    = vecs[i].ir;
         bus.i_ack = 1'b1;
         bus.d_ack = 1'b1;
         alu_zero  = vecs[i].az;
         #1;
         chk($sformatf("%s_fetch_state", vecs[i].name), 64'(state), 64'(ST_FETCH));
         chk($sformatf("%s_fetch_ld", vecs[i].name), 64'({bus.i_req, bus.ir_ld, pc_up}), 64'(3'b111));
         sb.push_back(vecs[i]);
         lat = 1;
         @(negedge clk); #1;
         lat++;
         chk($sformatf("%s_decode", vecs[i].name), 64'(state), 64'(ST_DECODE));
         chk($sformatf("%s_decode_outs", vecs[i].name), 64'(sample()), 64'(0));
         @(negedge clk); #1;
         lat++;
         cur = sb.pop_front();
         chk($sformatf("%s_exec_state", cur.name), 64'(state), 64'(cur.st));
         chk($sformatf("%s_exec_outs", cur.name), 64'(sample()), 64'(cur.exp));
         forever begin
            @(negedge clk); #1;
            if (state == 4'(ST_FETCH) || lat > 8) break;
            lat++;
         end
         chk($sformatf("%s_latency", cur.name), 64'(lat), 64'(cur.lat));
      end

      // LOAD with d_ack arriving in the 4th LOAD_A cycle
      bus.d_ack = 1'b0;
      alu_zero  = 1'b0;
      issue(16'h2AB3);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) @(negedge clk);
         bus.d_ack = (k == 4);
         #1;
         chk($sformatf("load_wait%0d_state", k), 64'(state), 64'(ST_LOAD_A));
         chk($sformatf("load_wait%0d_addr", k), 64'({bus.d_req, bus.d_addr}), 64'({1'b1, 8'hAB}));
      end
      @(negedge clk);
      bus.d_ack = 1'b0;
      #1;
      chk("load_b_state", 64'(state), 64'(ST_LOAD_B));
      e = '0; e.d_addr = 8'hAB; e.rf_s = 2'b01; e.w_addr = 4'h3; e.w_en = 1'b1;
      chk("load_b_outs", 64'(sample()), 64'(e));
      @(negedge clk); #1;
      chk("load_b_to_fetch", 64'(state), 64'(ST_FETCH));

      // HALT held without resume, released by resume
      resume = 1'b0;
      issue(16'h5000);
      chk("halt_enter", 64'({state, halted}), 64'({ST_HALT, 1'b1}));
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         chk($sformatf("halt_hold%0d", k), 64'({state, halted}), 64'({ST_HALT, 1'b1}));
      end
      resume = 1'b1;
      @(negedge clk); #1;
      chk("halt_resume", 64'({state, halted}), 64'({ST_FETCH, 1'b0}));
      @(negedge clk); #1;
      chk("resume_ignored_in_fetch", 64'(state), 64'(ST_FETCH));
      resume = 1'b0;

      // Asynchronous reset in the middle of a STORE wait
      bus.d_ack = 1'b0;
      issue(16'h1A5C);
      chk("store_req", 64'({state, bus.d_req, bus.d_wr}), 64'({ST_STORE, 2'b11}));
      @(negedge clk); #1;
      chk("store_req_held", 64'({state, bus.d_req}), 64'({ST_STORE, 1'b1}));
      Reset = 1'b0;
      #1;
      chk("store_reset_state", 64'(state), 64'(0));
      e = '0; e.pc_clr = 1'b1;
      chk("store_reset_outs", 64'(sample()), 64'(e));
      @(negedge clk); #1;
      Reset = 1'b1;
      #1;
      chk("store_reset_init", 64'({state, pc_clr}), 64'({ST_INIT, 1'b1}));
      @(negedge clk); #1;
      chk("store_reset_fetch", 64'({state, pc_clr}), 64'({ST_FETCH, 1'b0}));

      // Watchdog: no i_ack for TIMEOUT cycles traps to FAULT
      bus.i_ack = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         chk($sformatf("wd_wait%0d", k), 64'({state, fault}), 64'({ST_FETCH, 1'b0}));
      end
      @(negedge clk); #1;
      chk("wd_fault", 64'({state, fault}), 64'({ST_FAULT, 1'b1}));
      bus.i_ack = 1'b1; bus.d_ack = 1'b1; resume = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         chk($sformatf("wd_fault_hold%0d", k), 64'({state, fault}), 64'({ST_FAULT, 1'b1}));
      end
      bus.i_ack = 1'b0; bus.d_ack = 1'b0; resume = 1'b0;
      Reset = 1'b0;
      #1;
      chk("wd_fault_reset", 64'({state, fault, pc_clr}), 64'({4'd0, 1'b0, 1'b1}));
      @(negedge clk); #1;
      Reset = 1'b1;
      @(negedge clk); #1;
      chk("wd_after_reset_fetch", 64'(state), 64'(ST_FETCH));

      // Ack in the TIMEOUT-th cycle wins, twice, to show the count restarts
      for (int rep = 0; rep < 2; rep++) begin
         for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge clk);
            bus.ir    = 16'h0000;
            bus.i_ack = (k == 16);
            #1;
            chk($sformatf("wd_late_ack%0d_c%0d", rep, k), 64'({state, fault}), 64'({ST_FETCH, 1'b0}));
         end
         @(negedge clk);
         bus.i_ack = 1'b0;
         #1;
         chk($sformatf("wd_late_ack%0d_decode", rep), 64'({state, fault}), 64'({ST_DECODE, 1'b0}));
         @(negedge clk); #1;
         @(negedge clk); #1;
         chk($sformatf("wd_late_ack%0d_back", rep), 64'(state), 64'(ST_FETCH));
      end

      chk("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
